// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: funct3 access-size codes, opcodes used by the control decoder,
// and the state encoding of the data-memory responder.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for byte/half/word accesses: load lane select with
// sign/zero extension, store lane replication with byte enables, and misalignment detection.
module mem_lane_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o,
    output logic [3:0]  byte_en_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rword_i >> {addr_lo_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

        load_data_o = 32'h0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            F3_W:    load_data_o = rword_i;
            default: load_data_o = 32'h0;
        endcase

        // Narrow stores replicate the datum across the word so the byte enables pick the lane.
        store_data_o = 32'h0;
        byte_en_o    = 4'b0000;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                store_data_o = {4{wdata_i[7:0]}};
                byte_en_o    = 4'b0001 << addr_lo_i;
            end
            2'b01: begin
                store_data_o = {2{wdata_i[15:0]}};
                byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                store_data_o = wdata_i;
                byte_en_o    = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            default: begin
                store_data_o = 32'h0;
                byte_en_o    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for RV32I loads/stores: one request at a time, fixed-latency
// response pulse, internal word storage with byte-enable writes.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// WAIT  | request latched, counting down wait states
// RESP  | store already committed; response registered on leaving this state
module data_mem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic        rd_q, wr_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic              accept, enter_resp, mem_we;
    logic [31:0]       addr_c, wdata_c;
    logic [2:0]        f3_c;
    logic              rd_c, wr_c;
    logic [IDX_W-1:0]  idx_c;
    logic [31:0]       word_c, load_data, store_data;
    logic [3:0]        byte_en;
    logic              misaligned, out_of_range, f3_illegal, req_err;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_ready & req_valid & (mem_read | mem_write);

    // With zero wait states the store commits on the accept edge, before the latch is loaded.
    assign addr_c  = req_ready ? addr      : addr_q;
    assign wdata_c = req_ready ? wdata     : wdata_q;
    assign f3_c    = req_ready ? funct3    : f3_q;
    assign rd_c    = req_ready ? mem_read  : rd_q;
    assign wr_c    = req_ready ? mem_write : wr_q;

    assign idx_c        = addr_c[IDX_W+1:2];
    assign word_c       = mem[idx_c];
    assign out_of_range = {2'b00, addr_c[31:2]} >= 32'(DEPTH_WORDS);
    assign f3_illegal   = wr_c ? (f3_c >= 3'b011)
                               : ((f3_c == 3'b011) || (f3_c == 3'b110) || (f3_c == 3'b111));
    assign req_err      = misaligned | out_of_range | f3_illegal | (rd_c & wr_c);

    mem_lane_align u_align (
        .funct3_i     (f3_c),
        .addr_lo_i    (addr_c[1:0]),
        .rword_i      (word_c),
        .wdata_i      (wdata_c),
        .load_data_o  (load_data),
        .store_data_o (store_data),
        .byte_en_o    (byte_en),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_resp  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = req_err;
                rdata_d     = (req_err || !rd_c) ? 32'h0 : load_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            f3_q        <= 3'b000;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= funct3;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
            end
        end
    end

    // Storage is deliberately not reset; rst_n gating keeps an aborted store from landing.
    assign mem_we = enter_resp & wr_c & ~req_err & rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx_c][b*8 +: 8] <= store_data[b*8 +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-level reference memory model.
module tb_data_mem_responder;

    localparam int DEPTH  = 1024;
    localparam int WAITC  = 1;
    localparam int REGION = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [REGION];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the architectural effect of one access on a byte-addressed memory.
    function automatic void ref_access(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] exp_d, output logic exp_e);
        int          size;
        bit          legal;
        int          off;
        logic [31:0] w, val;
        exp_d = 32'h0;
        exp_e = 1'b0;
        if (wr && !rd)      legal = (f3 <= 3'd2);
        else if (rd && !wr) legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else                legal = 1'b0;
        if (!legal) begin
            exp_e = 1'b1;
            return;
        end
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'd0) || ((a / 4) >= DEPTH)) begin
            exp_e = 1'b1;
            return;
        end
        off = int'(a[1:0]);
        w   = ref_mem[a / 4];
        if (wr) begin
            for (int i = 0; i < size; i++) w[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
            ref_mem[a / 4] = w;
        end else begin
            val = w >> (off * 8);
            if (size == 1)      exp_d = f3[2] ? {24'h0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
            else if (size == 2) exp_d = f3[2] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
            else                exp_d = val;
        end
    endfunction

    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got_d);
        logic [31:0] exp_d;
        logic        exp_e;
        int          k;
        int          guard;
        guard = 0;
        got_d = 32'h0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        ref_access(rd, wr, f3, a, wd, exp_d, exp_e);
        @(negedge clk);
        req_valid = 1'b0;
        mem_read  = 1'($urandom); mem_write = 1'($urandom);
        funct3    = 3'($urandom); addr = $urandom; wdata = $urandom;
        k = 1;
        check({tag, " busy"}, 32'(req_ready), 32'd0);
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        got_d = rdata;
        check({tag, " latency"}, k, WAITC + 2);
        check({tag, " rdata"}, rdata, exp_d);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_e));
        @(negedge clk);
        check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          accepts, rsps, pulses;
        bit          prev_ready;
        logic        rd, wr;
        logic [31:0] a;
        int          sel;

        rst_n = 1'b0;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rdata, 32'h0);
        check("rst err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < REGION; i++) do_req("init sw", 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, got);

        do_req("sw 10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got);
        do_req("lw 10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got);
        check("lw 10 literal", got, 32'hDEADBEEF);
        do_req("lb 13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, got);
        check("lb 13 literal", got, 32'hFFFFFFDE);
        do_req("lbu 13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, got);
        check("lbu 13 literal", got, 32'h000000DE);
        do_req("lh 12", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, got);
        check("lh 12 literal", got, 32'hFFFFDEAD);
        do_req("sb 11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055, got);
        do_req("lw 10 after sb", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got);
        check("sb merge literal", got, 32'hDEAD55EF);
        do_req("lw 12 misalign", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, got);
        do_req("sh 11 misalign", 1'b0, 1'b1, 3'b001, 32'h11, 32'h0000BEEF, got);
        do_req("lw oob", 1'b1, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, got);
        do_req("lw 10 unchanged", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got);
        check("err no write literal", got, 32'hDEAD55EF);

        // Valid without read or write must be ignored.
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!req_ready) pulses++;
            if (rsp_valid) pulses++;
        end
        check("ignored req", pulses, 0);

        // Back-to-back loads with valid held high.
        mem_read = 1'b1; addr = 32'h10; funct3 = 3'b010;
        accepts = 0; rsps = 0; prev_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (prev_ready) check("b2b busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                rsps++;
                check("b2b rdata", rdata, 32'hDEAD55EF);
            end
            if (req_ready) accepts++;
            prev_ready = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0; mem_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) rsps++;
            @(negedge clk);
        end
        check("b2b accepts", accepts, (12 + WAITC + 1) / (WAITC + 2));
        check("b2b rsps", rsps, accepts);

        // Reset while a store waits: nothing written, nothing returned.
        do_req("sw 20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, got);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
        addr = 32'h20; wdata = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; mem_write = 1'b0;
        check("rst wait state", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst mid ready", 32'(req_ready), 32'd1);
        check("rst mid rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst no rsp", pulses, 0);
        do_req("lw 20 after rst", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, got);
        check("rst kept literal", got, 32'h11223344);

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 99));
            rd  = 1'($urandom);
            wr  = ~rd;
            if (sel < 5) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            if (sel >= 90)      a = 32'(DEPTH * 4) + $urandom_range(0, 4095);
            else if (sel >= 88) a = 32'hFFFFFFFC;
            else                a = $urandom_range(0, REGION * 4 - 1);
            do_req("rand", rd, wr, 3'($urandom), a, $urandom, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
